// File: rtl/nibble_add_seq.sv
// 16-bit add/subtract computed serially through one 4-bit ripple-carry slice,
// one nibble per clock (LSB first); fixed five-cycle latency from accept to done.
module nibble_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        ovf
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] sum_q, sum_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic        c_out_q, c_out_d;
    logic        ovf_q, ovf_d;

    logic [3:0] slice_a, slice_b, slice_s;
    logic [4:0] slice_c;

    assign slice_a    = a_q[{idx_q, 2'b00} +: 4];
    assign slice_b    = b_q[{idx_q, 2'b00} +: 4];
    assign slice_c[0] = carry_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign slice_s[gi]   = slice_a[gi] ^ slice_b[gi] ^ slice_c[gi];
            assign slice_c[gi+1] = (slice_a[gi] & slice_b[gi]) |
                                   (slice_c[gi] & (slice_a[gi] ^ slice_b[gi]));
        end
    endgenerate

    logic accept;
    assign accept = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_RUN: begin
                busy    = 1'b1;
                sum_d[{idx_q, 2'b00} +: 4] = slice_s;
                carry_d = slice_c[4];
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    c_out_d = slice_c[4];
                    // carry into bit 15 recovered from the sum bit itself
                    ovf_d   = (a_q[15] ^ b_q[15] ^ slice_s[3]) ^ slice_c[4];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            idx_d   = 2'd0;
            sum_d   = 16'd0;
            c_out_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            sum_q   <= 16'd0;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: the driver queues expected results,
// a negedge monitor checks each done pulse for value, latency and busy width.
module tb_nibble_add_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        busy, done, c_out, ovf;
    logic [15:0] sum;

    nibble_add_seq dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (busy && done) begin
            errors++;
            $display("FAIL busy_and_done actual=1 required=0 cycle=%0d", cyc);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual sum=%0h required=no_done cycle=%0d", sum, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %s: sum=%h c_out=%b ovf=%b cycle=%0d", e.name, sum, c_out, ovf, cyc);
                check({e.name, "_sum"}, 32'(sum), 32'(e.s));
                check({e.name, "_c_out"}, 32'(c_out), 32'(e.c));
                check({e.name, "_ovf"}, 32'(ovf), 32'(e.o));
                check({e.name, "_latency"}, 32'(cyc - e.acc), 32'd4);
                check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
            end
        end
        busy_cnt = busy ? busy_cnt + 1 : 0;
    end

    task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                      input logic [15:0] es, input logic ec, input logic eo, input string name);
        exp_t e;
        @(posedge clk); #1;
        a = av; b = bv; sub = sv; start = 1'b1;
        e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1; e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", 32'({c_out, ovf}), 32'd0);
        rst = 1'b0;

        op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        #1;
        check("hold_sum", 32'(sum), 32'h5555);
        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple");
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        op(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero");
        op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "add_negovf");
        op(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, "add_mid");

        // start during RUN must be ignored
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        e.s = 16'h3333; e.c = 1'b0; e.o = 1'b0; e.acc = cyc + 1; e.name = "ignore_start";
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0F0F; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);

        // start held high: back-to-back operations
        @(posedge clk); #1;
        a = 16'h0101; b = 16'h0202; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.s = 16'h0303; e.c = 1'b0; e.o = 1'b0; e.acc = cyc + 1 + 5 * i; e.name = "b2b";
            exp_q.push_back(e);
        end
        repeat (11) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);

        // reset in the third RUN cycle aborts the operation
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_flags", 32'({c_out, ovf}), 32'd0);
        repeat (6) @(posedge clk);
        op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, "after_abort");

        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
        end
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset. Reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin one operation; level-sampled on each rising edge.
REQ-005 sub  input  1  0 selects a+b; 1 selects a-b; sampled with start.
REQ-006 a  input  16  operand A; sampled with start.
REQ-007 b  input  16  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 sum  output  16  result; held until the next accepted start.
REQ-011 c_out  output  1  carry out of bit 15; for subtract, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement overflow of the 16-bit result.

Function
REQ-013 All addition SHALL pass through a single 4-bit ripple-carry adder slice (full-adder chain: a, b, c_in -> s[3:0], c_out), which processes one nibble per cycle, LSB nibble first.
REQ-014 The FSM SHALL have three states:
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1.
REQ-015 Start SHALL be accepted on a rising edge in IDLE or DONE when start=1. On acceptance:
- latch a into the A register;
- latch b into the B register, or ~b when sub=1;
- load the carry register with the value of sub;
- clear the nibble index to 0;
- clear sum, c_out and ovf;
- go to RUN.
REQ-016 In RUN, on each edge the block SHALL:
- add nibble[idx] of the A and B registers plus the carry register;
- write the 4-bit result into sum[4*idx+3:4*idx];
- store the slice carry-out in the carry register;
- increment idx modulo 4.
REQ-017 On the RUN edge with idx=3, the block SHALL:
- set c_out to the slice carry-out;
- set ovf = (carry into bit 15) XOR (carry out of bit 15), where carry into bit 15 = A[15] ^ B'[15] ^ sum[15] and B' is the latched, possibly inverted, B;
- go to DONE.
REQ-018 Latency SHALL be fixed: done is high exactly in the 5th cycle after the accepting edge (edges 1-4 process nibbles 0-3). It is independent of operand values and sub.
REQ-019 From DONE, the next edge SHALL go to IDLE when start=0, or accept a new operation per REQ-015 when start=1. Back-to-back throughput is one result per 5 cycles.
REQ-020 start SHALL be ignored while in RUN. Operand and sub changes during RUN SHALL NOT affect the result.
REQ-021 sum, c_out and ovf SHALL remain stable from the DONE cycle until the next accepting edge. Nibbles not yet written during RUN read as 0.
REQ-022 The 16-bit result SHALL wrap modulo 2^16. No saturation.
REQ-023 done SHALL never be high for two consecutive cycles unless a new operation has completed in between. busy and done SHALL never be high together.

Reset
REQ-024 On a rising edge with rst=1, the block SHALL enter IDLE and clear sum, c_out, ovf, busy, done, the idx register and the carry register to 0.
REQ-025 rst SHALL take priority over start.
REQ-026 rst during RUN SHALL abort the operation: no done pulse follows and partial sum nibbles are cleared.

Verification
REQ-027 a=0x1234, b=0x4321, sub=0, start pulse -> busy high for 4 cycles, then done for 1 cycle with sum=0x5555, c_out=0, ovf=0.
REQ-028 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, c_out=1, ovf=0 (carry ripples through all four nibbles); a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
REQ-029 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0 (borrow), ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
REQ-030 Start an operation (0x1111+0x2222); in the 2nd RUN cycle assert start with a=0xFFFF and change b -> request ignored; done after the normal 5 cycles with sum=0x3333.
REQ-031 start held high continuously with a=0x0101, b=0x0202 -> done pulses every 5 cycles, each with sum=0x0303; busy=0 only in the DONE cycles.
REQ-032 Assert rst for one cycle during the 3rd RUN cycle -> next cycle IDLE with all outputs 0 and no done pulse; a subsequent start completes normally.
